// File: rtl/imem_loader.sv
// Instruction-memory loader: receives header N plus N words over valid/ready, writes RAM from
// address 0, serves combinational fetches once loaded. Optional checksum word: IMEM_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              Clear,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [15:0]       PC,
    output logic [DATA_W-1:0] Instr,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_DONE,
        S_ERR
`ifdef IMEM_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   n_q, n_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;
    logic                wr_en;
    logic                finish;
    logic                xfer;
`ifdef IMEM_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_q, acc_d;
`endif

    logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

`ifdef IMEM_CHECKSUM_EN
    assign in_ready = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
`else
    assign in_ready = (state_q == S_HDR) || (state_q == S_LOAD);
`endif
    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
        finish  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    count_d = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_d = in_data;
`ifdef IMEM_CHECKSUM_EN
                    acc_d = in_data;
`endif
                    if (32'(in_data) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (in_data == '0) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    count_d = count_q + (ADDR_W+1)'(1);
`ifdef IMEM_CHECKSUM_EN
                    acc_d   = acc_q + in_data;
`endif
                    // Last word of the image: count before increment equals N-1
                    if (32'(count_q) + 32'd1 == 32'(n_q))
                        finish = 1'b1;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (in_data == acc_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
`ifdef IMEM_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
`ifdef IMEM_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
`ifdef IMEM_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // RAM is deliberately not reset; the image overwrites it on each load
    always_ff @(posedge clk) begin
        if (wr_en && Clear)
            mem[count_q[ADDR_W-1:0]] <= in_data;
    end

    assign Instr    = ((state_q == S_DONE) && (32'(PC) < 32'(n_q))) ? mem[PC[ADDR_W-1:0]] : '0;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected fetches are queued while images stream in,
// then drained against Instr once the load completes.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        Clear = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [15:0] PC = '0;
    logic [15:0] Instr;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  count;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_t;

    fetch_t      sb[$];
    logic [15:0] img[$];
    int          tests = 0;
    int          fails = 0;
    int          rdy_cycles;

    imem_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut (
        .clk(clk), .Clear(Clear), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .PC(PC), .Instr(Instr), .cpu_hold(cpu_hold), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word and hold it until the loader takes it; in_valid stays high afterwards
    task automatic stream_word(input logic [15:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        rdy_cycles++;
        tick();
    endtask

    // Streams header + img, queues the expected fetch results for each stored word
    task automatic send_image(input bit bad_csum);
        logic [15:0] sum;
        sum = 16'(img.size());
        stream_word(16'(img.size()));
        for (int i = 0; i < img.size(); i++) begin
            stream_word(img[i]);
            sum = sum + img[i];
            sb.push_back('{pc: 16'(i), instr: img[i]});
        end
`ifdef IMEM_CHECKSUM_EN
        stream_word(bad_csum ? sum + 16'd1 : sum);
`else
        if (bad_csum) sum = '0;
`endif
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        sb.push_back('{pc: 16'(img.size()), instr: 16'h0000});
        sb.push_back('{pc: 16'h0100 + 16'(img.size()), instr: 16'h0000});
    endtask

    task automatic drain(input string tag);
        fetch_t f;
        while (sb.size() > 0) begin
            f  = sb.pop_front();
            PC = f.pc;
            #1;
            check($sformatf("%s_pc%0h", tag, f.pc), 32'(Instr), 32'(f.instr));
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_ready", 32'(in_ready), 0);
        check("rst_hold", 32'(cpu_hold), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(count), 0);
        Clear = 1'b1;
        tick();
        check("idle_ready", 32'(in_ready), 0);

        // Basic 3-word image with in_valid held high
        pulse_start();
        check("hdr_ready", 32'(in_ready), 1);
        img = '{16'h1234, 16'h2345, 16'h3456};
        rdy_cycles = 0;
`ifdef IMEM_CHECKSUM_EN
        send_image(1'b0);
        check("t1_rdy_cycles", 32'(rdy_cycles), 5);
`else
        send_image(1'b0);
        check("t1_rdy_cycles", 32'(rdy_cycles), 4);
`endif
        check("t1_done", 32'(done), 1);
        check("t1_hold", 32'(cpu_hold), 0);
        check("t1_ready", 32'(in_ready), 0);
        check("t1_count", 32'(count), 3);
        drain("t1");

        // Empty image
        pulse_start();
        check("t2_hold", 32'(cpu_hold), 1);
        check("t2_done", 32'(done), 0);
        img = {};
        send_image(1'b0);
        check("t2_done", 32'(done), 1);
        check("t2_count", 32'(count), 0);
        sb.push_back('{pc: 16'h0001, instr: 16'h0000});
        drain("t2");

        // Oversized header goes to ERR, start recovers
        pulse_start();
        stream_word(16'h0101);
        in_valid = 1'b0;
        check("t3_err", 32'(err), 1);
        check("t3_hold", 32'(cpu_hold), 1);
        check("t3_ready", 32'(in_ready), 0);
        tick();
        check("t3_err_hold", 32'(err), 1);
        pulse_start();
        check("t3_err_clr", 32'(err), 0);
        check("t3_ready_hdr", 32'(in_ready), 1);

        // Backpressure mid-load with ignored start pulses
        stream_word(16'h0004);
        stream_word(16'hA001);
        in_valid = 1'b0;
        in_data  = 16'hBAD0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        check("t4_count_stall", 32'(count), 1);
        check("t4_ready_stall", 32'(in_ready), 1);
        stream_word(16'hA002);
        in_valid = 1'b0;
        check("t4_count2", 32'(count), 2);
        check("t4_done_early", 32'(done), 0);
        stream_word(16'hA003);
        stream_word(16'hA004);
        in_valid = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        stream_word(16'h0004 + 16'hA001 + 16'hA002 + 16'hA003 + 16'hA004);
        in_valid = 1'b0;
`endif
        check("t4_done", 32'(done), 1);
        check("t4_count", 32'(count), 4);
        sb.push_back('{pc: 16'h0000, instr: 16'hA001});
        sb.push_back('{pc: 16'h0001, instr: 16'hA002});
        sb.push_back('{pc: 16'h0003, instr: 16'hA004});
        sb.push_back('{pc: 16'h0004, instr: 16'h0000});
        drain("t4");

        // Reset after two of five words, then reload a 2-word image
        pulse_start();
        stream_word(16'h0005);
        stream_word(16'h1111);
        stream_word(16'h2222);
        in_valid = 1'b0;
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        check("t5_ready", 32'(in_ready), 0);
        check("t5_count", 32'(count), 0);
        check("t5_hold", 32'(cpu_hold), 1);
        tick();
        check("t5_no_restart", 32'(in_ready), 0);
        pulse_start();
        img = '{16'hABCD, 16'h0001};
        send_image(1'b0);
        check("t5_done", 32'(done), 1);
        drain("t5");

        // Largest legal image (N == DEPTH)
        pulse_start();
        img = {};
        for (int i = 0; i < 256; i++) img.push_back(16'(i * 3 + 1));
        send_image(1'b0);
        check("t6_done", 32'(done), 1);
        check("t6_count", 32'(count), 256);
        for (int i = 0; i < 250; i++) void'(sb.pop_front());
        drain("t6");

`ifdef IMEM_CHECKSUM_EN
        pulse_start();
        img = '{16'h0010, 16'h0020};
        send_image(1'b0);
        check("t7_done", 32'(done), 1);
        drain("t7");
        pulse_start();
        send_image(1'b1);
        check("t7_err", 32'(err), 1);
        check("t7_done_bad", 32'(done), 0);
        sb.delete();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. Owns the instruction RAM the CPU fetches from.
- Accepts a program image over a valid/ready word stream: a header word N, then N instruction words. It writes them to consecutive addresses from 0.
- Serves combinational fetches on PC/Instr. Holds the CPU in stall (cpu_hold) until the image is complete.

Parameters:
- ADDR_W, 8, instruction address width; words actually stored = 2^ADDR_W
- DATA_W, 16, instruction/stream word width
- DEPTH, 256, usable words; must be <= 2^ADDR_W

Ports:
- clk  in  1  rising-edge clock
- Clear  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse: begin (re)load
- in_valid  in  1  stream word present
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts in_data this cycle
- PC  in  16  fetch address from CPU
- Instr  out  DATA_W  fetched instruction, combinational
- cpu_hold  out  1  high = CPU must not advance PC
- done  out  1  image loaded successfully
- err  out  1  load aborted
- count  out  ADDR_W+1  words written in current load

Behaviour:
- Handshake:
  - A transfer occurs on a clk edge with in_valid && in_ready.
  - in_ready is registered-state decoded: high only in HDR, LOAD and CHK; low in IDLE, DONE and ERR.
  - in_data is ignored when no transfer occurs.
- Reset (Clear=0 at an edge): state IDLE, in_ready=0, cpu_hold=1, done=0, err=0, count=0, N register=0.
  - RAM contents are not cleared.
  - Reset mid-load aborts immediately; the next load needs a new start.
- FSM:
  - IDLE: start -> HDR.
  - HDR: on transfer, N := in_data. If N > DEPTH -> ERR. If N == 0 -> DONE, or CHK when the optional checksum is enabled. Otherwise -> LOAD.
  - LOAD: on transfer, write in_data at address count, then count := count+1. When the written word is the Nth (count == N-1 before increment) -> DONE, or CHK when the optional checksum is enabled.
  - DONE: done=1, cpu_hold=0. start -> HDR, count := 0, done := 0, cpu_hold := 1 from that edge.
  - ERR: err=1, cpu_hold=1. Only start (-> HDR, err := 0, count := 0) or reset exits.
- start in HDR, LOAD or CHK is ignored; start in IDLE, DONE or ERR is honoured.
- Write latency: a word transferred on edge k is readable on Instr after edge k.
- Fetch:
  - Instr = RAM[PC[ADDR_W-1:0]] when PC < N and state is DONE; otherwise 16'h0000.
  - The address truncation is explicit. PC >= N, including wrap beyond DEPTH, returns 0.
- cpu_hold is asserted from reset or start until the edge entering DONE. It is deasserted in the same cycle done rises.
- count saturates at N. It never exceeds DEPTH.
- in_ready=1 in LOAD on the final-word cycle; it drops the cycle after the transfer.

Optional Feature:
- IMEM_CHECKSUM_EN defined:
  - After the last data word (or after the header when N=0) the FSM enters CHK.
  - CHK accepts one word. Expected value = (N + sum of data words) mod 2^16.
  - Match -> DONE; mismatch -> ERR.
  - An accumulator register is cleared on start/reset.
- Undefined: CHK state and accumulator are absent; LOAD/HDR go directly to DONE. Stream is header + N words only.

Test Plan:
- Reset then start; stream 16'h0003, 16'h1234, 16'h2345, 16'h3456 with in_valid held high -> in_ready high 4 cycles. done=1 and cpu_hold=0 after 4th transfer. PC=1 gives Instr=16'h2345; PC=3 gives 16'h0000.
- Header 16'h0000 -> DONE next edge, no RAM write, Instr=0 for all PC. With IMEM_CHECKSUM_EN: extra word 16'h0000 required -> DONE.
- Header DEPTH+1 (16'h0101) -> err=1, cpu_hold=1, in_ready=0. A following start returns to HDR with err=0.
- Mid-load backpressure: in_valid toggles 1,0,0,1 during LOAD -> only 2 writes, count increments only on transfers. start pulses during LOAD are ignored.
- Clear=0 after 2 of 5 words -> IDLE, count=0, cpu_hold=1. Restart with 2-word image ABCD,0001 -> PC=0 gives 16'hABCD.
- IMEM_CHECKSUM_EN: header 2, data 16'h0010, 16'h0020, checksum 16'h0032 -> done. Same with checksum 16'h0033 -> err=1.
